// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Purpose  : Shared state encoding and J/K drive codes for the JK stimulus gen.
// Revision : 1.0
// ============================================================================
package jk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SETUP = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOW   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // {J, K} drive codes
  localparam logic [1:0] c_jk_hold   = 2'b00;
  localparam logic [1:0] c_jk_set    = 2'b10;
  localparam logic [1:0] c_jk_reset  = 2'b01;
  localparam logic [1:0] c_jk_toggle = 2'b11;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite
// Purpose  : JK excitation table: current Q and target Q to the J/K drive.
// Revision : 1.0
// ============================================================================
module jk_excite
  import jk_pkg::*;
(
  input  logic i_q_exp,
  input  logic i_t,
  input  logic i_use_toggle,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_jk;

  always_comb begin
    w_jk = c_jk_hold;
    if (i_q_exp != i_t) begin
      if (i_use_toggle) w_jk = c_jk_toggle;
      else if (i_t)     w_jk = c_jk_set;
      else              w_jk = c_jk_reset;
    end
  end

  assign o_j = w_jk[1];
  assign o_k = w_jk[0];

endmodule
`default_nettype wire

// File: rtl/jk_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : jk_stim_gen
// Purpose  : Drives a JK flip-flop through a target Q sequence with a slow
//            generated clock and counts steps where its Q disagrees.
// Revision : 1.0
// ============================================================================
module jk_stim_gen
  import jk_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int SETUP_CYC  = 5,
  parameter int HIGH_CYC   = 5,
  parameter int LOW_CYC    = 10,
  parameter int RST_CYC    = 10,
  parameter bit USE_TOGGLE = 1'b0,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [MAX_LEN-1:0] Pattern,
  input  logic [LEN_W-1:0]   Len,
  input  logic               Q_in,
  output logic               J,
  output logic               K,
  output logic               Ff_clk,
  output logic               Ff_rst_n,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [LEN_W-1:0]   Err_cnt,
  output logic [LEN_W-1:0]   First_err_idx
);

  localparam int c_ph_a   = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int c_ph_b   = (LOW_CYC > RST_CYC) ? LOW_CYC : RST_CYC;
  localparam int c_ph_max = (c_ph_a > c_ph_b) ? c_ph_a : c_ph_b;
  localparam int c_ph_w   = $clog2(c_ph_max + 1);

  localparam logic [c_ph_w-1:0] c_rst_last   = c_ph_w'(RST_CYC - 1);
  localparam logic [c_ph_w-1:0] c_setup_last = c_ph_w'(SETUP_CYC - 1);
  localparam logic [c_ph_w-1:0] c_high_last  = c_ph_w'(HIGH_CYC - 1);
  localparam logic [c_ph_w-1:0] c_low_last   = c_ph_w'(LOW_CYC - 1);
  localparam logic [c_ph_w-1:0] c_ph_one     = c_ph_w'(1);
  localparam logic [LEN_W-1:0]  c_max_len    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  c_idx_one    = LEN_W'(1);

  state_t               r_state;
  logic [c_ph_w-1:0]    r_ph;
  logic [LEN_W-1:0]     r_idx;
  logic [LEN_W-1:0]     r_len;
  logic [MAX_LEN-1:0]   r_pattern;
  logic                 r_q_exp;
  logic                 r_j;
  logic                 r_k;
  logic                 r_ff_clk;
  logic                 r_ff_rst_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [LEN_W-1:0]     r_err_cnt;
  logic [LEN_W-1:0]     r_first_err;

  logic [MAX_LEN:0]     w_pat_ext;
  logic [LEN_W-1:0]     w_idx_next;
  logic [LEN_W-1:0]     w_len_clamped;
  logic                 w_t;
  logic                 w_last;
  logic                 w_miss;
  logic                 w_ex_q;
  logic                 w_ex_t;
  logic                 w_ex_j;
  logic                 w_ex_k;

  // Zero pad so the look-ahead to step idx+1 stays in range after the last step
  assign w_pat_ext     = {1'b0, r_pattern};
  assign w_idx_next    = r_idx + c_idx_one;
  assign w_len_clamped = (Len > c_max_len) ? c_max_len : Len;
  assign w_t           = w_pat_ext[r_idx];
  assign w_last        = (w_idx_next == r_len);
  assign w_miss        = (Q_in != w_t);

  // In LOW the excitation looks ahead to the next step, with q_exp already
  // advanced to the current target.
  assign w_ex_q = (r_state == ST_LOW) ? w_t : r_q_exp;
  assign w_ex_t = (r_state == ST_LOW) ? w_pat_ext[w_idx_next] : w_t;

  jk_excite u_excite (
    .i_q_exp     (w_ex_q),
    .i_t         (w_ex_t),
    .i_use_toggle(USE_TOGGLE),
    .o_j         (w_ex_j),
    .o_k         (w_ex_k)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_IDLE;
      r_ph        <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_pattern   <= '0;
      r_q_exp     <= 1'b0;
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_ff_clk    <= 1'b0;
      r_ff_rst_n  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            r_state     <= ST_INIT;
            r_ph        <= '0;
            r_idx       <= '0;
            r_len       <= w_len_clamped;
            r_pattern   <= Pattern;
            r_q_exp     <= 1'b0;
            r_j         <= 1'b0;
            r_k         <= 1'b0;
            r_ff_clk    <= 1'b0;
            r_ff_rst_n  <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
          end
        end

        ST_INIT: begin
          if (r_ph == c_rst_last) begin
            r_ph       <= '0;
            r_ff_rst_n <= 1'b1;
            if (r_len == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SETUP;
              r_j     <= w_ex_j;
              r_k     <= w_ex_k;
            end
          end else begin
            r_ph <= r_ph + c_ph_one;
          end
        end

        ST_SETUP: begin
          if (r_ph == c_setup_last) begin
            r_ph     <= '0;
            r_state  <= ST_HIGH;
            r_ff_clk <= 1'b1;
          end else begin
            r_ph <= r_ph + c_ph_one;
          end
        end

        ST_HIGH: begin
          if (r_ph == c_high_last) begin
            r_ph     <= '0;
            r_state  <= ST_LOW;
            r_ff_clk <= 1'b0;
          end else begin
            r_ph <= r_ph + c_ph_one;
          end
        end

        ST_LOW: begin
          if (r_ph == c_low_last) begin
            r_ph    <= '0;
            r_q_exp <= w_t;
            r_idx   <= w_idx_next;
            if (w_miss) begin
              r_err <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + c_idx_one;
              if (r_err_cnt == '0) r_first_err <= r_idx;
            end
            if (w_last) begin
              r_state <= ST_DONE;
              r_j     <= 1'b0;
              r_k     <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SETUP;
              r_j     <= w_ex_j;
              r_k     <= w_ex_k;
            end
          end else begin
            r_ph <= r_ph + c_ph_one;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign J             = r_j;
  assign K             = r_k;
  assign Ff_clk        = r_ff_clk;
  assign Ff_rst_n      = r_ff_rst_n;
  assign Busy          = r_busy;
  assign Done          = r_done;
  assign Err           = r_err;
  assign Err_cnt       = r_err_cnt;
  assign First_err_idx = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_stim_gen
// Purpose  : Random and directed sequences against two generators (set/reset
//            and toggle encodings), each driving a behavioural JK flip-flop.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_jk_stim_gen;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int S       = 20;
  localparam int R       = 10;
  localparam int HC      = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      pattern;
  logic [LEN_W-1:0] len;
  logic             tie0;

  logic             q0, q1;
  logic             j0, k0, ffc0, ffr0, busy0, done0, err0;
  logic             j1, k1, ffc1, ffr1, busy1, done1, err1;
  logic [LEN_W-1:0] errc0, fidx0, errc1, fidx1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jk_stim_gen #(.USE_TOGGLE(1'b0)) u_dut0 (
    .Clk(clk), .Rst(rst), .Start(start), .Pattern(pattern), .Len(len),
    .Q_in(tie0 ? 1'b0 : q0), .J(j0), .K(k0), .Ff_clk(ffc0), .Ff_rst_n(ffr0),
    .Busy(busy0), .Done(done0), .Err(err0), .Err_cnt(errc0), .First_err_idx(fidx0)
  );

  jk_stim_gen #(.USE_TOGGLE(1'b1)) u_dut1 (
    .Clk(clk), .Rst(rst), .Start(start), .Pattern(pattern), .Len(len),
    .Q_in(tie0 ? 1'b0 : q1), .J(j1), .K(k1), .Ff_clk(ffc1), .Ff_rst_n(ffr1),
    .Busy(busy1), .Done(done1), .Err(err1), .Err_cnt(errc1), .First_err_idx(fidx1)
  );

  // Flip-flops under test
  always @(posedge ffc0 or negedge ffr0)
    if (!ffr0) q0 <= 1'b0;
    else       q0 <= (j0 & ~q0) | (~k0 & q0);

  always @(posedge ffc1 or negedge ffr1)
    if (!ffr1) q1 <= 1'b0;
    else       q1 <= (j1 & ~q1) | (~k1 & q1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference {J,K}: hold when the target does not change, otherwise toggle
  // or an explicit set/reset towards the new value.
  function automatic logic [1:0] ref_jk(input logic prev, input logic t, input bit tog);
    if (prev == t) return 2'b00;
    if (tog)       return 2'b11;
    return {t, ~t};
  endfunction

  task automatic run(input logic [15:0] pat, input logic [LEN_W-1:0] ln, input bit t0,
                     input int busy_start_cyc);
    int L, cyc, np0, np1, nh0;
    logic p0, p1, prev, t, qa0, qa1;
    logic [1:0] jk0_q[$];
    logic [1:0] jk1_q[$];
    logic [1:0] e0, e1;
    int ec0, ec1, fi0, fi1;
    L = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
    @(negedge clk);
    pattern = pat; len = ln; tie0 = t0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("start_busy", busy0, 1);
    chk("start_done", done0, 0);
    chk("start_errcnt", errc0, 0);
    chk("start_ffrst", ffr0, 0);
    p0 = 1'b0; p1 = 1'b0; np0 = 0; np1 = 0; nh0 = 0;
    while (!done0 && cyc < 1000) begin
      if (ffc0 && !p0) begin jk0_q.push_back({j0, k0}); np0++; end
      if (ffc1 && !p1) begin jk1_q.push_back({j1, k1}); np1++; end
      if (ffc0) nh0++;
      p0 = ffc0; p1 = ffc1;
      start = (cyc == busy_start_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, R + L * S + 1);
    chk("done1", done1, 1);
    chk("pulses0", np0, L);
    chk("pulses1", np1, L);
    chk("high_cycles", nh0, L * HC);
    prev = 1'b0; qa0 = 1'b0; qa1 = 1'b0;
    ec0 = 0; ec1 = 0; fi0 = 0; fi1 = 0;
    for (int i = 0; i < L; i++) begin
      t  = pat[i];
      e0 = ref_jk(prev, t, 1'b0);
      e1 = ref_jk(prev, t, 1'b1);
      chk($sformatf("jk0_step%0d", i), (i < jk0_q.size()) ? jk0_q[i] : 2'bxx, e0);
      chk($sformatf("jk1_step%0d", i), (i < jk1_q.size()) ? jk1_q[i] : 2'bxx, e1);
      qa0 = t0 ? 1'b0 : ((e0[1] & ~qa0) | (~e0[0] & qa0));
      qa1 = t0 ? 1'b0 : ((e1[1] & ~qa1) | (~e1[0] & qa1));
      if (qa0 != t) begin if (ec0 == 0) fi0 = i; ec0++; end
      if (qa1 != t) begin if (ec1 == 0) fi1 = i; ec1++; end
      prev = t;
    end
    chk("errcnt0", errc0, ec0);
    chk("errcnt1", errc1, ec1);
    chk("err0", err0, ec0 != 0);
    chk("err1", err1, ec1 != 0);
    if (ec0 != 0) chk("first_idx0", fidx0, fi0);
    if (ec1 != 0) chk("first_idx1", fidx1, fi1);
    chk("done_jk", {j0, k0, j1, k1}, 0);
    chk("done_busy", busy0, 0);
    chk("done_ffclk", ffc0, 0);
    chk("done_ffrst", ffr0, 1);
    if (L > 0 && !t0) chk("final_q", q0, pat[L-1]);
  endtask

  task automatic rst_test();
    int cyc, np;
    logic p;
    @(negedge clk);
    pattern = 16'h00FF; len = 5'd8; tie0 = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; np = 0; p = 1'b0;
    while (np < 3 && cyc < 200) begin
      if (ffc0 && !p) np++;
      p = ffc0;
      if (np < 3) begin @(negedge clk); cyc++; end
    end
    chk("rst_reached_step2", np, 3);
    chk("pre_rst_errcnt", errc0, 2);
    chk("pre_rst_ffclk", ffc0, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_ffclk", ffc0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ffrst", ffr0, 0);
    chk("rst_errcnt", errc0, 0);
    chk("rst_err", err0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst_idle_busy", busy0, 0);
    chk("rst_idle_done", done0, 0);
    chk("rst_idle_ffclk", ffc0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; tie0 = 1'b0;
    #12;
    chk("reset_jk", {j0, k0, j1, k1}, 0);
    chk("reset_ctl", {ffc0, ffr0, busy0, done0, err0}, 0);
    chk("reset_cnt", {errc0, fidx0}, 0);
    @(negedge clk);
    rst = 1'b0;

    run(16'b1101, 5'd4, 1'b0, 0);
    run(16'b011, 5'd3, 1'b1, 0);
    run(16'b1101, 5'd4, 1'b0, 0);
    run(16'hA5C3, 5'd0, 1'b0, 0);
    run(16'h3C96, 5'd20, 1'b0, 40);
    rst_test();
    for (int n = 0; n < 12; n++)
      run(16'($urandom), 5'($urandom_range(0, 18)), ($urandom % 4) == 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
